instr_fetch: RTL and testbench

//   Fetch stage directly upstream of the byte-addressable instruction memory (imem).

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, the canonical NOP and the
// {pc, instr} record that travels from fetch to decode.
package riscv_pkg;

  localparam int          XLEN       = 32;
  localparam int          INSTR_W    = 32;
  localparam int          ILEN_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads imem combinationally, buffers {pc, instr}
// pairs for decode and handles redirects, backpressure and fetch faults.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault_misalign,
  output logic        fault_range
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - ILEN_BYTES);
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_pc;
  logic          r_fault_misalign;
  logic          r_fault_range;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;

  logic          w_pop;
  logic          w_push;
  logic          w_in_range;
  logic          w_fault_any;
  logic [31:0]   w_pc_next;
  logic          w_misalign_next;
  logic          w_range_next;

  assign iaddr          = r_pc;
  assign fault_misalign = r_fault_misalign;
  assign fault_range    = r_fault_range;

  assign w_in_range  = (r_pc <= LAST_PC);
  assign w_fault_any = r_fault_misalign || r_fault_range;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = !redirect_valid && !w_fault_any && w_in_range && (!w_full || w_pop);
  assign w_wdata     = '{pc: r_pc, instr: idata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Stale storage behind an empty FIFO is never exposed to decode.
  always_comb begin
    out_valid = (w_count != '0);
    out_pc    = w_empty ? '0 : w_head.pc;
    out_instr = w_empty ? '0 : w_head.instr;
  end

  always_comb begin
    w_pc_next       = r_pc;
    w_misalign_next = r_fault_misalign;
    w_range_next    = r_fault_range;
    if (redirect_valid) begin
      w_pc_next       = redirect_pc;
      w_misalign_next = (redirect_pc[1:0] != 2'b00);
      w_range_next    = 1'b0;
    end else begin
      if (w_push)      w_pc_next    = r_pc + 32'(ILEN_BYTES);
      if (!w_in_range) w_range_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_fault_misalign <= 1'b0;
      r_fault_range    <= 1'b0;
    end else begin
      r_pc             <= w_pc_next;
      r_fault_misalign <= w_misalign_next;
      r_fault_range    <= w_range_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based model of the fetch stage.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault_misalign;
  logic        fault_range;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault_misalign (fault_misalign),
    .fault_range    (fault_range)
  );

  // imem: 128 bytes, little-endian words, combinational read
  logic [7:0] mem [0:127];
  logic [6:0] ia;
  always_comb begin
    ia = iaddr[6:0];
    if (iaddr <= 32'd124) idata = {mem[ia + 7'd3], mem[ia + 7'd2], mem[ia + 7'd1], mem[ia]};
    else                  idata = 32'hDEAD_BEEF;
  end

  // reference model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_fm;
  logic        m_fr;

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [6:0] b;
    b = a[6:0];
    return {mem[b + 7'd3], mem[b + 7'd2], mem[b + 7'd1], mem[b]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    m_fm = 1'b0;
    m_fr = 1'b0;
  endtask

  task automatic model_step();
    bit          pop;
    int          n;
    logic [31:0] pc0;
    n   = q.size();
    pop = (n != 0) && out_ready;
    pc0 = m_pc;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc;
      m_fm = (redirect_pc % 4) != 0;
      m_fr = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_fm && !m_fr && pc0 <= 32'd124 && (n < 2 || pop)) begin
        q.push_back('{pc: pc0, instr: mword(pc0)});
        m_pc = pc0 + 32'd4;
      end
      if (pc0 > 32'd124) m_fr = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic        ev;
    logic [31:0] ep;
    logic [31:0] ei;
    ev = (q.size() != 0);
    ep = ev ? q[0].pc : 32'h0;
    ei = ev ? q[0].instr : 32'h0;
    chk({ph, ".valid"}, 32'(out_valid), 32'(ev));
    chk({ph, ".pc"}, out_pc, ep);
    chk({ph, ".instr"}, out_instr, ei);
    chk({ph, ".iaddr"}, iaddr, m_pc);
    chk({ph, ".fmis"}, 32'(fault_misalign), 32'(m_fm));
    chk({ph, ".frng"}, 32'(fault_range), 32'(m_fr));
  endtask

  task automatic cycle(input string ph);
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic redirect(input logic [31:0] pc, input string ph);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle(ph);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    // ADDI x1, x0, i at word i: every word distinct
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
      {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]} = w;
    end
    model_reset();
    #1;
    check_all("reset0");
    cycle("reset1");
    cycle("reset2");

    // T1: release reset, decode always ready
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle("t1");

    // T2: stall fills the FIFO, then resume
    out_ready = 1'b0;
    repeat (5) cycle("t2_stall");
    out_ready = 1'b1;
    repeat (4) cycle("t2_resume");

    // T3: redirect while full
    out_ready = 1'b0;
    repeat (3) cycle("t3_fill");
    redirect(32'h40, "t3_redir");
    chk("t3_valid_drop", 32'(out_valid), 32'h0);
    chk("t3_iaddr", iaddr, 32'h40);
    cycle("t3_after");
    chk("t3_head", out_pc, 32'h40);

    // T4: misaligned redirect, then recover
    redirect(32'h42, "t4_mis");
    chk("t4_fault_set", 32'(fault_misalign), 32'h1);
    out_ready = 1'b1;
    repeat (3) cycle("t4_halt");
    chk("t4_no_push", 32'(out_valid), 32'h0);
    redirect(32'h10, "t4_fix");
    chk("t4_fault_clr", 32'(fault_misalign), 32'h0);
    cycle("t4_head");
    chk("t4_head_pc", out_pc, 32'h10);
    repeat (3) cycle("t4_run");

    // T5: run off the end of imem
    redirect(32'h78, "t5_redir");
    repeat (4) cycle("t5_run");
    chk("t5_frng", 32'(fault_range), 32'h1);
    chk("t5_iaddr", iaddr, 32'h80);
    chk("t5_drained", 32'(out_valid), 32'h0);
    redirect(32'h0, "t5_clear");
    chk("t5_frng_clr", 32'(fault_range), 32'h0);

    // T6: async reset between edges with a full FIFO
    out_ready = 1'b0;
    repeat (3) cycle("t6_fill");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_iaddr", iaddr, 32'h0);
    chk("t6_async_pc", out_pc, 32'h0);
    model_reset();
    cycle("t6_hold");
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle("t6_run");

    // T7: async reset also clears a sticky fault
    redirect(32'h46, "t7_mis");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t7_async_fmis", 32'(fault_misalign), 32'h0);
    model_reset();
    cycle("t7_hold");
    rst = 1'b0;

    // random traffic
    for (int k = 0; k < 400; k++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        1:       redirect_pc = {25'd0, 7'($urandom_range(0, 127))};
        2:       redirect_pc = 32'h70 + 32'(4 * $urandom_range(0, 5));
        default: redirect_pc = $urandom();
      endcase
      cycle("rnd");
    end
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
